// File: rtl/genie_pkg.sv
// Shared encodings for the layer sequencer:
// descriptor opcodes, field positions, FSM states, mux selects.
package genie_pkg;

    localparam int AW_DEF = 26;

    localparam logic [3:0] OP_END     = 4'd0;
    localparam logic [3:0] OP_CONV    = 4'd1;
    localparam logic [3:0] OP_MAXPOOL = 4'd2;

    localparam int OP_LSB = 28;
    localparam int C_LSB  = 0;
    localparam int H_LSB  = 16;
    localparam int W_LSB  = 0;
    localparam int DIM_W  = 11;
    localparam int ADDR_W = 27;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_RUN,
        S_NEXT,
        S_FINISH,
        S_ERROR
    } state_e;

    typedef enum logic [1:0] {
        SEL_SELF,
        SEL_CV,
        SEL_MP
    } sel_e;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_CONV) || (op == OP_MAXPOOL);
    endfunction

endpackage

// File: rtl/layer_sched_if.sv
// Word-addressed memory channel: separate read and write
// request/ready handshakes with a 32-bit data path.
interface layer_sched_if #(
    parameter int AW = 26
);
    logic          wvalid;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          rvalid;
    logic [AW-1:0] raddr;
    logic          wready;
    logic          rready;
    logic [31:0]   rdata;

    modport master (
        output wvalid, waddr, wdata, rvalid, raddr,
        input  wready, rready, rdata
    );

    modport slave (
        input  wvalid, waddr, wdata, rvalid, raddr,
        output wready, rready, rdata
    );
endinterface

// File: rtl/mem_port_mux.sv
// Routes the single external memory port to the sequencer
// itself or to one engine; the others see ready/rdata at zero.
module mem_port_mux
    import genie_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  sel_e          sel,
    input  logic          self_rvalid,
    input  logic [AW-1:0] self_raddr,
    output logic          self_rready,
    output logic [31:0]   self_rdata,
    layer_sched_if.slave  cv,
    layer_sched_if.slave  mp,
    layer_sched_if.master mem
);

    always_comb begin
        mem.wvalid = 1'b0;
        mem.waddr  = '0;
        mem.wdata  = '0;
        mem.rvalid = self_rvalid;
        mem.raddr  = self_raddr;
        unique case (sel)
            SEL_CV: begin
                mem.wvalid = cv.wvalid;
                mem.waddr  = cv.waddr;
                mem.wdata  = cv.wdata;
                mem.rvalid = cv.rvalid;
                mem.raddr  = cv.raddr;
            end
            SEL_MP: begin
                mem.wvalid = mp.wvalid;
                mem.waddr  = mp.waddr;
                mem.wdata  = mp.wdata;
                mem.rvalid = mp.rvalid;
                mem.raddr  = mp.raddr;
            end
            default: ;
        endcase
    end

    // Response side kept separate so no comb loop appears via ready.
    always_comb begin
        self_rready = 1'b0;
        self_rdata  = '0;
        cv.wready   = 1'b0;
        cv.rready   = 1'b0;
        cv.rdata    = '0;
        mp.wready   = 1'b0;
        mp.rready   = 1'b0;
        mp.rdata    = '0;
        unique case (sel)
            SEL_CV: begin
                cv.wready = mem.wready;
                cv.rready = mem.rready;
                cv.rdata  = mem.rdata;
            end
            SEL_MP: begin
                mp.wready = mem.wready;
                mp.rready = mem.rready;
                mp.rdata  = mem.rdata;
            end
            default: begin
                self_rready = mem.rready;
                self_rdata  = mem.rdata;
            end
        endcase
    end

endmodule

// File: rtl/layer_sched.sv
// Layer sequencer: walks a linked list of 4-word descriptors,
// programs the layer bus and runs the conv / max-pool engines.
module layer_sched
    import genie_pkg::*;
#(
    parameter int N_LAYER_MAX = 64,
    parameter int AW          = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] desc_base,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    layer_idx,
    output logic [10:0]   C,
    output logic [10:0]   H,
    output logic [10:0]   W,
    output logic [26:0]   ifaddr,
    output logic [26:0]   ofaddr,
    output logic          cv_rst,
    output logic          mp_rst,
    input  logic          cv_done,
    input  logic          mp_done,
    layer_sched_if.slave  cv,
    layer_sched_if.slave  mp,
    layer_sched_if.master mem
);

    state_e        state, state_n;
    logic [AW-1:0] desc_ptr;
    logic [AW-1:0] raddr;
    logic          rd_req;
    logic [1:0]    k;
    logic          lcnt;
    logic [3:0]    op_q;
    logic [10:0]   c_q, h_q, w_q;
    logic [26:0]   if_q, of_q;
    logic          self_rready;
    logic [31:0]   self_rdata;
    sel_e          sel;
    logic          is_conv;
    logic          eng_done;
    logic          rd_fire;
    logic          last_layer;
    logic [3:0]    op_in;
    logic          unused_rdata;

    assign is_conv      = (op_q == OP_CONV);
    assign eng_done     = is_conv ? cv_done : mp_done;
    assign rd_fire      = (state == S_FETCH) && rd_req && self_rready;
    assign last_layer   = (int'(layer_idx) + 1) >= N_LAYER_MAX;
    assign op_in        = self_rdata[OP_LSB +: 4];
    assign unused_rdata = self_rdata[ADDR_W];

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_FINISH);
    assign cv_rst = !((state == S_RUN) && is_conv);
    assign mp_rst = !((state == S_RUN) && !is_conv);
    assign sel    = (state != S_RUN) ? SEL_SELF
                  : (is_conv ? SEL_CV : SEL_MP);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (start) state_n = S_FETCH;
            S_FETCH: begin
                if (rd_fire) begin
                    if (k == 2'd0 && op_in == OP_END)
                        state_n = S_FINISH;
                    else if (k == 2'd0 && !op_legal(op_in))
                        state_n = S_ERROR;
                    else if (k == 2'd3)
                        state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: if (lcnt) state_n = S_RUN;
            S_RUN:    if (eng_done) state_n = S_NEXT;
            S_NEXT:   state_n = last_layer ? S_ERROR : S_FETCH;
            S_FINISH, S_ERROR: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            desc_ptr  <= '0;
            raddr     <= '0;
            rd_req    <= 1'b0;
            k         <= '0;
            lcnt      <= 1'b0;
            op_q      <= '0;
            c_q       <= '0;
            h_q       <= '0;
            w_q       <= '0;
            if_q      <= '0;
            of_q      <= '0;
            layer_idx <= '0;
            err       <= 1'b0;
            C         <= '0;
            H         <= '0;
            W         <= '0;
            ifaddr    <= '0;
            ofaddr    <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                desc_ptr  <= desc_base;
                layer_idx <= '0;
                err       <= 1'b0;
                k         <= '0;
            end
            // Request is raised one cycle after the previous word lands.
            if (state == S_FETCH) begin
                if (!rd_req) begin
                    rd_req <= 1'b1;
                    raddr  <= desc_ptr + AW'(k);
                end else if (self_rready) begin
                    rd_req <= 1'b0;
                    k      <= k + 2'd1;
                    unique case (k)
                        2'd0: begin
                            op_q <= op_in;
                            c_q  <= self_rdata[C_LSB +: DIM_W];
                        end
                        2'd1: begin
                            h_q <= self_rdata[H_LSB +: DIM_W];
                            w_q <= self_rdata[W_LSB +: DIM_W];
                        end
                        2'd2:    if_q <= self_rdata[ADDR_W-1:0];
                        default: of_q <= self_rdata[ADDR_W-1:0];
                    endcase
                end
            end
            if (state == S_LAUNCH) begin
                lcnt <= !lcnt;
                if (!lcnt) begin
                    C      <= c_q;
                    H      <= h_q;
                    W      <= w_q;
                    ifaddr <= if_q;
                    ofaddr <= of_q;
                end
            end
            if (state == S_NEXT) begin
                desc_ptr <= desc_ptr + AW'(4);
                if (int'(layer_idx) < N_LAYER_MAX)
                    layer_idx <= layer_idx + 8'd1;
            end
            if (state_n == S_ERROR) err <= 1'b1;
        end
    end

    mem_port_mux #(.AW(AW)) u_mux (
        .sel         (sel),
        .self_rvalid (rd_req),
        .self_raddr  (raddr),
        .self_rready (self_rready),
        .self_rdata  (self_rdata),
        .cv          (cv),
        .mp          (mp),
        .mem         (mem)
    );

endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: memory model with optional
// random latency, hand-driven engine done/memory traffic.
module tb_layer_sched;
    import genie_pkg::*;

    localparam int AW = 26;
    localparam int NL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] desc_base = '0;
    logic          busy, done, err;
    logic [7:0]    layer_idx;
    logic [10:0]   C, H, W;
    logic [26:0]   ifaddr, ofaddr;
    logic          cv_rst, mp_rst;
    logic          cv_done = 1'b0;
    logic          mp_done = 1'b0;

    layer_sched_if #(.AW(AW)) cv_i ();
    layer_sched_if #(.AW(AW)) mp_i ();
    layer_sched_if #(.AW(AW)) mem_i ();

    layer_sched #(.N_LAYER_MAX(NL), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .desc_base (desc_base),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .layer_idx (layer_idx),
        .C         (C),
        .H         (H),
        .W         (W),
        .ifaddr    (ifaddr),
        .ofaddr    (ofaddr),
        .cv_rst    (cv_rst),
        .mp_rst    (mp_rst),
        .cv_done   (cv_done),
        .mp_done   (mp_done),
        .cv        (cv_i),
        .mp        (mp_i),
        .mem       (mem_i)
    );

    always #5 clk = ~clk;

    logic [31:0]   mem_arr [256];
    int            wcnt = 0;
    int            rnd_lat = 0;
    int            fixed_lat = 0;
    bit            rand_lat = 1'b0;
    logic [AW-1:0] fetch_log [$];
    int            both_low = 0;
    int            leak = 0;
    int            eng_on = 0;
    int            done_cnt = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    assign mem_i.rready = mem_i.rvalid &&
        (wcnt >= (rand_lat ? rnd_lat : fixed_lat));
    assign mem_i.wready = 1'b1;
    assign mem_i.rdata  = mem_arr[mem_i.raddr[7:0]];

    always @(posedge clk) begin
        if (mem_i.rvalid && !mem_i.rready) wcnt <= wcnt + 1;
        else                               wcnt <= 0;
        if (mem_i.rvalid && mem_i.rready) begin
            rnd_lat <= int'($urandom_range(0, 5));
            if (cv_rst && mp_rst) fetch_log.push_back(mem_i.raddr);
        end
    end

    always @(posedge clk)
        if (mem_i.wvalid && mem_i.wready)
            mem_arr[mem_i.waddr[7:0]] = mem_i.wdata;

    always @(negedge clk) begin
        if (!cv_rst && !mp_rst) both_low <= both_low + 1;
        if (!cv_rst || !mp_rst) eng_on <= eng_on + 1;
        if (cv_rst && (cv_i.rready || cv_i.wready || cv_i.rdata != 0))
            leak <= leak + 1;
        if (mp_rst && (mp_i.rready || mp_i.wready || mp_i.rdata != 0))
            leak <= leak + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic [AW-1:0] base);
        @(negedge clk);
        desc_base = base;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_run(input bit conv, input string tag,
                            output int cyc);
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if ((conv ? cv_rst : mp_rst) == 1'b0) begin
                cyc = i;
                break;
            end
        end
        check({tag, " reached"}, 64'(cyc != 0), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                c = i;
                break;
            end
        end
        check({tag, " idle"}, 64'(c != 0), 64'd1);
    endtask

    task automatic pulse_done(input bit conv);
        if (conv) cv_done = 1'b1;
        else      mp_done = 1'b1;
        @(negedge clk);
        cv_done = 1'b0;
        mp_done = 1'b0;
    endtask

    task automatic put_desc(input int a, input logic [3:0] op,
                            input int c, input int h, input int w,
                            input int ia, input int oa);
        mem_arr[a]   = {op, 17'd0, 11'(c)};
        mem_arr[a+1] = {5'd0, 11'(h), 5'd0, 11'(w)};
        mem_arr[a+2] = {5'd0, 27'(ia)};
        mem_arr[a+3] = {5'd0, 27'(oa)};
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int cyc, d0, l0, e0, got;
        logic [31:0] rd;

        cv_i.wvalid = 1'b0; cv_i.waddr = '0; cv_i.wdata = '0;
        cv_i.rvalid = 1'b0; cv_i.raddr = '0;
        mp_i.wvalid = 1'b0; mp_i.waddr = '0; mp_i.wdata = '0;
        mp_i.rvalid = 1'b0; mp_i.raddr = '0;

        for (int i = 0; i < 256; i++) mem_arr[i] = 32'(i) ^ 32'hA5A5_0000;
        put_desc(16, OP_MAXPOOL, 2, 4, 4, 'h100, 'h200);
        mem_arr[20] = 32'h0;
        put_desc(64, OP_CONV, 3, 5, 6, 'h1000, 'h2000);
        put_desc(68, OP_MAXPOOL, 1, 2, 2, 'h3000, 'h4000);
        mem_arr[72] = 32'h0;
        put_desc(128, OP_CONV, 7, 9, 10, 'h5555, 'h6666);
        mem_arr[132] = 32'h0;
        mem_arr[32]  = 32'hCAFE_F00D;
        mem_arr[33]  = 32'h0;
        mem_arr[160] = 32'h7000_0000;
        for (int i = 0; i < 4; i++)
            put_desc(192 + 4 * i, OP_MAXPOOL, i + 1, 1, 1, i, i);

        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst err", 64'(err), 64'd0);
        check("rst cv_rst", 64'(cv_rst), 64'd1);
        check("rst mp_rst", 64'(mp_rst), 64'd1);
        check("rst rvalid", 64'(mem_i.rvalid), 64'd0);
        check("rst wvalid", 64'(mem_i.wvalid), 64'd0);
        check("rst layer_idx", 64'(layer_idx), 64'd0);
        check("rst C", 64'(C), 64'd0);
        check("rst ifaddr", 64'(ifaddr), 64'd0);
        rst = 1'b0;

        // single maxpool layer, 1-cycle memory
        kick(AW'('h10));
        wait_run(1'b0, "t1 run", cyc);
        check("t1 latency", 64'(cyc), 64'd11);
        check("t1 C", 64'(C), 64'd2);
        check("t1 H", 64'(H), 64'd4);
        check("t1 W", 64'(W), 64'd4);
        check("t1 ifaddr", 64'(ifaddr), 64'h100);
        check("t1 ofaddr", 64'(ofaddr), 64'h200);
        check("t1 cv_rst", 64'(cv_rst), 64'd1);
        check("t1 layer_idx", 64'(layer_idx), 64'd0);
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        pulse_done(1'b0);
        wait_idle("t1");
        check("t1 done pulses", 64'(done_cnt - d0), 64'd1);
        check("t1 err", 64'(err), 64'd0);

        // conv, maxpool, end at 0x40
        l0 = fetch_log.size();
        kick(AW'('h40));
        wait_run(1'b1, "t2 conv run", cyc);
        check("t2 idx0", 64'(layer_idx), 64'd0);
        check("t2 C0", 64'(C), 64'd3);
        check("t2 H0", 64'(H), 64'd5);
        check("t2 W0", 64'(W), 64'd6);
        check("t2 ifaddr0", 64'(ifaddr), 64'h1000);
        check("t2 ofaddr0", 64'(ofaddr), 64'h2000);
        pulse_done(1'b0);
        check("t2 inactive done", 64'(cv_rst), 64'd0);
        pulse_done(1'b1);
        wait_run(1'b0, "t2 mp run", cyc);
        check("t2 idx1", 64'(layer_idx), 64'd1);
        check("t2 C1", 64'(C), 64'd1);
        check("t2 H1", 64'(H), 64'd2);
        check("t2 ofaddr1", 64'(ofaddr), 64'h4000);
        pulse_done(1'b0);
        check("t2 first-cycle done", 64'(mp_rst), 64'd1);
        wait_idle("t2");
        check("t2 reads", 64'(fetch_log.size() - l0), 64'd9);
        for (int i = 0; i < 9 && l0 + i < fetch_log.size(); i++)
            check($sformatf("t2 raddr%0d", i),
                  64'(fetch_log[l0 + i]), 64'('h40 + i));

        // random memory latency, engine reads and writes
        rand_lat = 1'b1;
        kick(AW'('h80));
        wait_run(1'b1, "t3 run", cyc);
        check("t3 C", 64'(C), 64'd7);
        check("t3 H", 64'(H), 64'd9);
        check("t3 W", 64'(W), 64'd10);
        check("t3 ifaddr", 64'(ifaddr), 64'h5555);
        check("t3 ofaddr", 64'(ofaddr), 64'h6666);
        cv_i.raddr = AW'(32);
        cv_i.rvalid = 1'b1;
        got = 0;
        rd = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cv_i.rready) begin
                rd = cv_i.rdata;
                got = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cv_i.rvalid = 1'b0;
        check("t3 rd handshake", 64'(got), 64'd1);
        check("t3 rdata", 64'(rd), 64'hCAFE_F00D);
        cv_i.waddr = AW'(33);
        cv_i.wdata = 32'h1234;
        cv_i.wvalid = 1'b1;
        #1 check("t3 wready", 64'(cv_i.wready), 64'd1);
        @(negedge clk);
        cv_i.wvalid = 1'b0;
        check("t3 mem write", 64'(mem_arr[33]), 64'h1234);
        pulse_done(1'b1);
        wait_idle("t3");
        rand_lat = 1'b0;

        // illegal opcode
        l0 = fetch_log.size();
        e0 = eng_on;
        kick(AW'('hA0));
        wait_idle("t4");
        check("t4 err", 64'(err), 64'd1);
        check("t4 busy", 64'(busy), 64'd0);
        check("t4 reads", 64'(fetch_log.size() - l0), 64'd1);
        check("t4 engines held", 64'(eng_on - e0), 64'd0);
        kick(AW'('h10));
        check("t4 err cleared", 64'(err), 64'd0);
        wait_run(1'b0, "t4 rerun", cyc);
        pulse_done(1'b0);
        wait_idle("t4 rerun");

        // layer limit without END, start during RUN
        d0 = done_cnt;
        kick(AW'('hC0));
        for (int i = 0; i < 3; i++) begin
            wait_run(1'b0, $sformatf("t5 run%0d", i), cyc);
            check($sformatf("t5 idx%0d", i), 64'(layer_idx), 64'(i));
            check($sformatf("t5 C%0d", i), 64'(C), 64'(i + 1));
            if (i == 0) begin
                desc_base = AW'('h10);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("t5 start ignored", 64'(mp_rst), 64'd0);
                check("t5 idx kept", 64'(layer_idx), 64'd0);
            end
            pulse_done(1'b0);
        end
        wait_idle("t5");
        check("t5 err", 64'(err), 64'd1);
        check("t5 idx sat", 64'(layer_idx), 64'd3);
        check("t5 no done", 64'(done_cnt - d0), 64'd0);

        // reset mid-RUN with a pending engine read
        kick(AW'('h40));
        wait_run(1'b1, "t6 run", cyc);
        fixed_lat = 5;
        cv_i.raddr = AW'(32);
        cv_i.rvalid = 1'b1;
        #1 check("t6 rvalid lent", 64'(mem_i.rvalid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6 busy", 64'(busy), 64'd0);
        check("t6 cv_rst", 64'(cv_rst), 64'd1);
        check("t6 mp_rst", 64'(mp_rst), 64'd1);
        check("t6 rvalid", 64'(mem_i.rvalid), 64'd0);
        check("t6 C", 64'(C), 64'd0);
        check("t6 ifaddr", 64'(ifaddr), 64'd0);
        check("t6 done", 64'(done), 64'd0);
        cv_i.rvalid = 1'b0;
        fixed_lat = 0;
        rst = 1'b0;
        kick(AW'('h10));
        wait_run(1'b0, "t6 rerun", cyc);
        check("t6 rerun latency", 64'(cyc), 64'd11);
        check("t6 rerun C", 64'(C), 64'd2);
        d0 = done_cnt;
        pulse_done(1'b0);
        wait_idle("t6 rerun");
        check("t6 rerun done", 64'(done_cnt - d0), 64'd1);

        check("both engines out of reset", 64'(both_low), 64'd0);
        check("inactive engine ready", 64'(leak), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sched.md
# layer_sched

Top-level layer sequencer for the inference engine. Fetches a linked list of 4-word layer descriptors from external memory and programs the shared layer bus (C, H, W, ifaddr, ofaddr). Launches the matching engine (convolution or max-pool data loader) by releasing its reset, waits for its `done`, then advances to the next descriptor. Owns the single external memory port, using it for descriptor fetch and lending it to the active engine during a layer.

## Interface
Parameters:
- `N_LAYER_MAX`, 64: descriptors processed before `err` is raised.
- `AW`, 26: external memory word-address width.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin program at `desc_base`; sampled only in IDLE.
- `desc_base`  in  AW  word address of descriptor 0; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse on END descriptor.
- `err`  out  1  sticky until next `start` or `rst`.
- `layer_idx`  out  8  index of current descriptor.
- `C`, `H`, `W`  out  11 each  layer bus, registered.
- `ifaddr`, `ofaddr`  out  27 each  layer bus, registered.
- `cv_rst`, `mp_rst`  out  1 each  engine resets; high unless that engine is running.
- `cv_done`, `mp_done`  in  1 each  engine completion pulses.
- `cv_wvalid`, `cv_waddr`, `cv_wdata`, `cv_rvalid`, `cv_raddr`  in  1/AW/32/1/AW  conv memory request channel.
- `cv_wready`, `cv_rready`, `cv_rdata`  out  1/1/32  conv memory response channel.
- `mp_*`  same 8 signals, same directions and widths, for the max-pool loader.
- `mem_wvalid`, `mem_waddr`, `mem_wdata`, `mem_rvalid`, `mem_raddr`  out  1/AW/32/1/AW  external memory request.
- `mem_wready`, `mem_rready`, `mem_rdata`  in  1/1/32  external memory response.

## Operation
Descriptor layout, 4 consecutive words:
- w0: [31:28] op (0 END, 1 CONV, 2 MAXPOOL, other = illegal); [10:0] C.
- w1: [26:16] H; [10:0] W.
- w2: [26:0] ifaddr.
- w3: [26:0] ofaddr.

States:
- IDLE: on `start`, load `desc_ptr` = `desc_base`, clear `layer_idx` and `err`, go to FETCH.
- FETCH: read words k = 0..3 at `desc_ptr`+k.
  - Hold `mem_rvalid`/`mem_raddr` registered until `mem_rready`.
  - Capture `mem_rdata` in the `mem_rready` cycle.
  - Drop `mem_rvalid` for one cycle between words.
  - After w0, if op is END: skip w1..w3 and go to FINISH.
  - After w0, if op is illegal: go to ERROR.
- LAUNCH: drive the layer bus from the captured words; keep both engine resets high for 2 cycles.
- RUN: deassert only the selected engine's reset; wait for its `done`.
- NEXT: reassert that engine's reset; `desc_ptr` += 4; `layer_idx` += 1.
  - If `layer_idx` reaches `N_LAYER_MAX`, go to ERROR; otherwise go to FETCH.
- FINISH: pulse `done` for one cycle; go to IDLE.
- ERROR: set `err`; both engines held in reset; go to IDLE.

Memory ownership:
- In RUN, `mem_*` request signals are a combinational mux of the active engine's channel.
- `mem_rready`, `mem_wready` and `mem_rdata` route to the active engine only; the inactive engine sees ready = 0 and rdata = 0.
- Outside RUN, `mem_wvalid` = 0 and the read channel is driven from internal registers; engine requests are ignored.

Other rules:
- Address arithmetic: `desc_ptr` is AW bits and wraps modulo 2^AW without error.
- `layer_idx` saturates at `N_LAYER_MAX`.

## Timing
- Reset values: `busy`, `done`, `err`, `mem_wvalid`, `mem_rvalid` = 0; `cv_rst`, `mp_rst` = 1; layer bus, addresses, `layer_idx` = 0; state IDLE.
- `rst` mid-operation: all reset values apply on the next edge, including engines held in reset, so any in-flight memory transaction is abandoned.
- `start` while busy: ignored, no effect.
- Minimum per-layer overhead with 1-cycle memory: 4 words × 2 cycles + 2 LAUNCH + 1 NEXT = 11 cycles.
- Engine `done` arriving in the first RUN cycle is honoured.
- `done` on the inactive engine is ignored.
- Engine reset deasserts exactly on the cycle the state enters RUN.
- The layer bus is stable from the last LAUNCH cycle until the following FETCH completes.

## Structure
- Shared package `genie_pkg`: op encodings (`OP_END`, `OP_CONV`, `OP_MAXPOOL`), descriptor field bit positions, state enum, `AW` default.
- One sub-module, `mem_port_mux`: combinational 3-way mux for the memory channel (self / conv / maxpool) with ready and rdata gating.
- The FSM, descriptor registers and counters live in `layer_sched`.

## Test plan
- Single MAXPOOL descriptor (C=2, H=4, W=4, ifaddr=0x100, ofaddr=0x200), then END → layer bus matches and `mp_rst` falls; engine model pulses `mp_done` → `done` pulses once and `busy` falls.
- CONV then MAXPOOL then END at `desc_base`=0x40 → reads 0x40..0x43, 0x44..0x47, 0x48 in order; `cv_rst` and `mp_rst` are never both low; `layer_idx` = 0, then 1.
- Memory with random 0–5 cycle `mem_rready` latency during fetch and RUN → captured fields are correct; inactive engine never sees ready = 1.
- op = 7 in w0 → `err` = 1 after one read, both engines stay in reset, `busy` = 0; next `start` clears `err`.
- `N_LAYER_MAX` = 3 with no END → `err` after the 3rd `mp_done`; `start` pulsed during RUN → ignored.
- `rst` asserted mid-RUN with `mem_rvalid` high → next cycle all outputs at reset values and engines held in reset; fresh `start` reruns correctly.
